// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER pipeline types and constants
package otter_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/otter_fetch_fifo.sv
// otter_fetch_fifo: small skid buffer of fetched {ir, pc}; head is the IF/ID register
module otter_fetch_fifo
    import otter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    // Circular buffer; clear beats push so a squashed word never lands
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
            end
            if (pop_i) rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
`ifndef SYNTHESIS
    // The issue credit rule must keep the buffer within bounds
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i) begin
            assert (!(push_i && !pop_i && count_q == FULL)) else $error("fetch fifo overflow");
            assert (!(pop_i && count_q == '0)) else $error("fetch fifo underflow");
        end
    end
`endif
endmodule

// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: PC ownership, credit-limited BRAM fetch, skid-buffered IF/ID
module otter_fetch_stage
    import otter_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_ir,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);
    logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q;
    logic            inflight_q;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic            valid, pop, push;
    fetch_entry_t    head, push_entry;
    if_id_t          if_id;
    // Issue/pop/push decisions and IF/ID presentation; redirect overrides everything but reset
    always_comb begin
        occ        = {1'b0, count} + (CW + 1)'(inflight_q);
        valid      = ~RST & (count != '0);
        pop        = valid & ~id_stall & ~ex_redirect;
        push       = ~RST & ~ex_redirect & inflight_q;
        push_entry = '{ir: imem_rdata, pc: inflight_pc_q};
        imem_req   = ~RST & (ex_redirect | (occ < FULL) | (pop & (occ == FULL)));
        imem_addr  = ex_redirect ? word_align(ex_redirect_pc) : pc_q;
        pc_d       = imem_req ? imem_addr + XLEN'(4) : pc_q;
        if_id      = '{valid: valid,
                       ir:    valid ? head.ir : INSTR_NOP,
                       pc:    valid ? head.pc : '0,
                       pc4:   valid ? head.pc + XLEN'(4) : '0};
    end
    // PC and the single outstanding-request tracker
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= word_align(RESET_PC);
            inflight_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= imem_addr;
        end
    end
    otter_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clear_i    (ex_redirect),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .count_o    (count),
        .head_o     (head)
    );
    assign if_id_valid = if_id.valid;
    assign if_id_ir    = if_id.ir;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc4   = if_id.pc4;
endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb_otter_fetch_stage: scoreboard bench with program-order reference model
module tb_otter_fetch_stage;
    import otter_pkg::*;
    localparam logic [31:0] RPC = 32'h0000_0100;
    logic        CLK = 1'b0;
    logic        RST = 1'b1, id_stall = 1'b0, ex_redirect = 1'b0;
    logic [31:0] ex_redirect_pc = '0;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_ir, if_id_pc, if_id_pc4;
    int tests = 0, fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_pc = RPC;
    int since = -1, sreq = 0;
    bit nostall = 1'b1, hold = 1'b0;
    logic [31:0] prev_pc, prev_ir;

    always #5 CLK = ~CLK;

    otter_fetch_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_stall(id_stall), .ex_redirect(ex_redirect),
        .ex_redirect_pc(ex_redirect_pc), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous BRAM: data for an accepted request appears next cycle, garbage otherwise
    always @(posedge CLK) imem_rdata <= imem_req ? memf(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order: instructions are delivered sequentially from the last reset/redirect target
    task automatic drive(input logic r, input logic s, input logic x, input logic [31:0] t);
        @(posedge CLK);
        #1;
        RST = r; id_stall = s; ex_redirect = x; ex_redirect_pc = t;
        if (r) begin
            exp_q.delete();
            next_pc = RPC;
        end else if (x) begin
            exp_q.delete();
            next_pc = {t[31:2], 2'b00};
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc += 32'd4;
        end
    endtask

    // Monitor: checks every cycle's outputs against the reference behaviour
    always @(negedge CLK) begin
        if (RST) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_valid", 32'(if_id_valid), 32'd0);
            check("rst_ir", if_id_ir, INSTR_NOP);
            since = -1; nostall = 1'b1; hold = 1'b0; sreq = 0;
        end else begin
            if (ex_redirect) begin
                check("redir_req", 32'(imem_req), 32'd1);
                check("redir_addr", imem_addr, {ex_redirect_pc[31:2], 2'b00});
                since = 0; nostall = 1'b1;
            end else since++;
            if (since == 1) check("lat_invalid", 32'(if_id_valid), 32'd0);
            if (since == 2 || (since > 2 && nostall)) check("lat_stream_valid", 32'(if_id_valid), 32'd1);
            if (since >= 2) nostall &= ~id_stall;
            if (hold) begin
                check("hold_valid", 32'(if_id_valid), 32'd1);
                check("hold_pc", if_id_pc, prev_pc);
                check("hold_ir", if_id_ir, prev_ir);
            end
            if (!if_id_valid) begin
                check("inv_ir", if_id_ir, INSTR_NOP);
                check("inv_pc", if_id_pc, 32'd0);
                check("inv_pc4", if_id_pc4, 32'd0);
            end
            if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (if_id_valid && !id_stall && !ex_redirect) begin
                if (exp_q.size() == 0) check("sb_empty", if_id_pc, 32'hFFFF_FFFF);
                else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", if_id_pc, e);
                    check("sb_ir", if_id_ir, memf(e));
                    check("sb_pc4", if_id_pc4, e + 32'd4);
                end
            end
            if (if_id_valid && id_stall && !ex_redirect) begin
                if (imem_req) begin
                    sreq++;
                    check("stall_credit", 32'(sreq > 1), 32'd0);
                end
            end else sreq = 0;
            hold = if_id_valid && id_stall && !ex_redirect;
            prev_pc = if_id_pc;
            prev_ir = if_id_ir;
        end
    end

    initial begin
        int n;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            @(negedge CLK);
            check("seq_req", 32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, RPC + 32'(4 * k));
        end
        n = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            @(negedge CLK);
            check("stall_head_pc", if_id_pc, RPC + 32'h10);
            if (imem_req) n++;
        end
        check("stall_reqs_le2", 32'(n > 2), 32'd0);
        check("stall_req_off", 32'(imem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            @(negedge CLK);
            check("release_valid", 32'(if_id_valid), 32'd1);
            check("release_pc", if_id_pc, RPC + 32'h10 + 32'(4 * k));
        end
        repeat (3) drive(1'b0, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0203);
        @(negedge CLK);
        check("redir_same_addr", imem_addr, 32'h0000_0200);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("redir_next_invalid", 32'(if_id_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("redir_pc0", if_id_pc, 32'h0000_0200);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("redir_pc1", if_id_pc, 32'h0000_0204);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("redir_stall_pc", if_id_pc, 32'h0000_0040);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("wrap_pc0", if_id_pc, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("wrap_pc1", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_id_pc4, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("wrap_pc2", if_id_pc, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0800);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0900);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("rst_restart_addr", imem_addr, RPC);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        check("rst_restart_pc", if_id_pc, RPC);
        for (int k = 0; k < 3000; k++) begin
            logic r, s, x;
            logic [31:0] t;
            r = ($urandom_range(99) < 1);
            x = ($urandom_range(99) < 5);
            s = ($urandom_range(99) < 30);
            t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            drive(r, s, x, t);
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
